feature_weight_transform: RTL and testbench

- Combination stage of the GCN accelerator. Computes FM_WB = FM × WB, one output element at a time, using a serial multiply-accumulate engine.
- Issues element read addresses to the feature and weight memories and writes each finished dot product to the FM_WB buffer.
- Steps its feature row with the external feature row counter by driving enable_feature and reading back count. That counter clears on reset, increments on enable, and wraps from FEATURE_ROWS-1 to 0.
- Sits directly upstream of the feature counter and downstream of the memory loaders.

---
 rtl/gcn_pkg.sv | 26 ++
 rtl/feature_weight_transform_if.sv | 34 +++
 rtl/dot_product_mac.sv | 39 +++
 rtl/feature_weight_transform.sv | 120 ++++++++++++
 tb/tb_feature_weight_transform.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gcn_pkg.sv
// Shared GCN accelerator types, default matrix dimensions and widths.
// Imported by the combination stage and the feature row counter.
package gcn_pkg;

    localparam int FEATURE_ROWS  = 6;
    localparam int FEATURE_COLS  = 96;
    localparam int WEIGHT_COLS   = 3;
    localparam int FEATURE_WIDTH = 5;
    localparam int WEIGHT_WIDTH  = 5;
    localparam int DOT_WIDTH     = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } transform_state_t;

    // Index width that stays legal for a dimension of one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feature_weight_transform_if.sv
// Memory read ports and FM_WB write port of the combination stage.
// master: the transform; slave: the memories and FM_WB buffer.
interface feature_weight_transform_if #(
    parameter int COL_WIDTH     = 7,
    parameter int WCOL_WIDTH    = 2,
    parameter int ROW_WIDTH     = 3,
    parameter int FEATURE_WIDTH = 5,
    parameter int WEIGHT_WIDTH  = 5,
    parameter int DOT_WIDTH     = 16
);

    logic [COL_WIDTH-1:0]     feature_col;
    logic [FEATURE_WIDTH-1:0] feature_data;
    logic [COL_WIDTH-1:0]     weight_row;
    logic [WCOL_WIDTH-1:0]    weight_col;
    logic [WEIGHT_WIDTH-1:0]  weight_data;
    logic                     fm_wb_write_en;
    logic [ROW_WIDTH-1:0]     fm_wb_row;
    logic [WCOL_WIDTH-1:0]    fm_wb_col;
    logic [DOT_WIDTH-1:0]     fm_wb_data;

    modport master (
        output feature_col, weight_row, weight_col,
        output fm_wb_write_en, fm_wb_row, fm_wb_col, fm_wb_data,
        input  feature_data, weight_data
    );

    modport slave (
        input  feature_col, weight_row, weight_col,
        input  fm_wb_write_en, fm_wb_row, fm_wb_col, fm_wb_data,
        output feature_data, weight_data
    );

endinterface

// File: rtl/dot_product_mac.sv
// Serial unsigned multiply-accumulate; operands arrive one cycle after
// the cycle flagged by valid. Accumulator wraps modulo 2^ACC_WIDTH.
module dot_product_mac #(
    parameter int A_WIDTH   = 5,
    parameter int B_WIDTH   = 5,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic [ACC_WIDTH-1:0] acc
);

    localparam int PW = A_WIDTH + B_WIDTH;

    logic          valid_q;
    logic [PW-1:0] prod;

    assign prod = {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid;
            if (valid_q) begin
                acc <= acc + ACC_WIDTH'(prod);
            end
        end
    end

endmodule

// File: rtl/feature_weight_transform.sv
// GCN combination stage: FM_WB = FM x WB, one element per serial dot
// product, written column-major while stepping the feature row counter.
module feature_weight_transform #(
    parameter int FEATURE_ROWS          = gcn_pkg::FEATURE_ROWS,
    parameter int FEATURE_COLS          = gcn_pkg::FEATURE_COLS,
    parameter int WEIGHT_COLS           = gcn_pkg::WEIGHT_COLS,
    parameter int FEATURE_WIDTH         = gcn_pkg::FEATURE_WIDTH,
    parameter int WEIGHT_WIDTH          = gcn_pkg::WEIGHT_WIDTH,
    parameter int DOT_WIDTH             = gcn_pkg::DOT_WIDTH,
    parameter int COUNTER_FEATURE_WIDTH = gcn_pkg::idx_w(FEATURE_ROWS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [COUNTER_FEATURE_WIDTH-1:0] feature_count,
    output logic                             enable_feature,
    output logic                             busy,
    output logic                             done,
    feature_weight_transform_if.master       mem
);

    import gcn_pkg::*;

    localparam int KW  = idx_w(FEATURE_COLS);
    localparam int WCW = idx_w(WEIGHT_COLS);

    transform_state_t state, state_n;
    logic [KW-1:0]        k, k_n;
    logic [WCW-1:0]       w, w_n;
    logic [DOT_WIDTH-1:0] acc;

    always_comb begin
        state_n = state;
        k_n     = k;
        w_n     = w;
        unique case (state)
            IDLE:  if (start) state_n = CLEAR;
            CLEAR: begin
                k_n     = '0;
                state_n = MAC;
            end
            MAC: begin
                if (k == KW'(FEATURE_COLS - 1)) state_n = DRAIN;
                else k_n = k + 1'b1;
            end
            DRAIN: state_n = WRITE;
            WRITE: begin
                state_n = CLEAR;
                if (feature_count == COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1)) begin
                    if (w == WCW'(WEIGHT_COLS - 1)) begin
                        state_n = DONE;
                        w_n     = '0;
                    end else begin
                        w_n = w + 1'b1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            w     <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            w     <= w_n;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy               <= 1'b0;
            done               <= 1'b0;
            enable_feature     <= 1'b0;
            mem.fm_wb_write_en <= 1'b0;
            mem.fm_wb_row      <= '0;
            mem.fm_wb_col      <= '0;
            mem.feature_col    <= '0;
            mem.weight_row     <= '0;
            mem.weight_col     <= '0;
        end else begin
            busy               <= (state_n != IDLE);
            done               <= (state_n == DONE);
            enable_feature     <= (state_n == WRITE);
            mem.fm_wb_write_en <= (state_n == WRITE);
            if (state_n == MAC) begin
                mem.feature_col <= k_n;
                mem.weight_row  <= k_n;
                mem.weight_col  <= w_n;
            end
            if (state_n == WRITE) begin
                mem.fm_wb_row <= feature_count;
                mem.fm_wb_col <= w_n;
            end
        end
    end

    dot_product_mac #(
        .A_WIDTH  (FEATURE_WIDTH),
        .B_WIDTH  (WEIGHT_WIDTH),
        .ACC_WIDTH(DOT_WIDTH)
    ) u_mac (
        .clk  (clk),
        .reset(reset),
        .clear(state == CLEAR),
        .valid(state == MAC),
        .a    (mem.feature_data),
        .b    (mem.weight_data),
        .acc  (acc)
    );

    assign mem.fm_wb_data = acc;

endmodule

// File: tb/tb_feature_weight_transform.sv
// Directed bench for feature_weight_transform: small, default and C=1
// configurations, each with its own memory and feature counter model.
module tb_feature_weight_transform;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int en_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int r, input int c, input int d);
        return {8'(r), 8'(c), 16'(d)};
    endfunction

    // Small: R=2 C=3 W=2
    logic       start_s = 1'b0;
    logic [0:0] cnt_s;
    logic       en_s, busy_s, done_s;
    logic [4:0] fm_s [0:1][0:2];
    logic [4:0] wm_s [0:2][0:1];
    logic [31:0] q_s[$];
    int done_at_s = -1;

    feature_weight_transform_if #(
        .COL_WIDTH(2), .WCOL_WIDTH(1), .ROW_WIDTH(1),
        .FEATURE_WIDTH(5), .WEIGHT_WIDTH(5), .DOT_WIDTH(16)
    ) if_s ();

    feature_weight_transform #(
        .FEATURE_ROWS(2), .FEATURE_COLS(3), .WEIGHT_COLS(2)
    ) dut_s (
        .clk(clk), .reset(reset), .start(start_s),
        .feature_count(cnt_s), .enable_feature(en_s),
        .busy(busy_s), .done(done_s), .mem(if_s.master)
    );

    always @(posedge clk or posedge reset)
        if (reset) cnt_s <= '0;
        else if (en_s) cnt_s <= (cnt_s == 1'd1) ? 1'd0 : cnt_s + 1'b1;

    always @(posedge clk) begin
        if_s.feature_data <= fm_s[cnt_s][if_s.feature_col];
        if_s.weight_data  <= wm_s[if_s.weight_row][if_s.weight_col];
    end

    always @(negedge clk) begin
        if (if_s.fm_wb_write_en)
            q_s.push_back({8'(if_s.fm_wb_row), 8'(if_s.fm_wb_col), if_s.fm_wb_data});
        if (en_s !== if_s.fm_wb_write_en) en_bad++;
        if (done_s) done_at_s = cyc;
    end

    // Default: R=6 C=96 W=3
    logic       start_d = 1'b0;
    logic [2:0] cnt_d;
    logic       en_d, busy_d, done_d;
    logic [4:0] fm_d [0:5][0:95];
    logic [4:0] wm_d [0:95][0:2];
    logic [31:0] q_d[$];
    int done_at_d = -1;

    feature_weight_transform_if #(
        .COL_WIDTH(7), .WCOL_WIDTH(2), .ROW_WIDTH(3),
        .FEATURE_WIDTH(5), .WEIGHT_WIDTH(5), .DOT_WIDTH(16)
    ) if_d ();

    feature_weight_transform dut_d (
        .clk(clk), .reset(reset), .start(start_d),
        .feature_count(cnt_d), .enable_feature(en_d),
        .busy(busy_d), .done(done_d), .mem(if_d.master)
    );

    always @(posedge clk or posedge reset)
        if (reset) cnt_d <= '0;
        else if (en_d) cnt_d <= (cnt_d == 3'd5) ? 3'd0 : cnt_d + 1'b1;

    always @(posedge clk) begin
        if_d.feature_data <= fm_d[cnt_d][if_d.feature_col];
        if_d.weight_data  <= wm_d[if_d.weight_row][if_d.weight_col];
    end

    always @(negedge clk) begin
        if (if_d.fm_wb_write_en)
            q_d.push_back({8'(if_d.fm_wb_row), 8'(if_d.fm_wb_col), if_d.fm_wb_data});
        if (en_d !== if_d.fm_wb_write_en) en_bad++;
        if (done_d) done_at_d = cyc;
    end

    // Single column: R=2 C=1 W=1, feature 7, weight 3
    logic       start_1 = 1'b0;
    logic [0:0] cnt_1;
    logic       en_1, busy_1, done_1;
    logic [31:0] q_1[$];
    int done_at_1 = -1;
    int first_wr_1 = -1;

    feature_weight_transform_if #(
        .COL_WIDTH(1), .WCOL_WIDTH(1), .ROW_WIDTH(1),
        .FEATURE_WIDTH(5), .WEIGHT_WIDTH(5), .DOT_WIDTH(16)
    ) if_1 ();

    feature_weight_transform #(
        .FEATURE_ROWS(2), .FEATURE_COLS(1), .WEIGHT_COLS(1)
    ) dut_1 (
        .clk(clk), .reset(reset), .start(start_1),
        .feature_count(cnt_1), .enable_feature(en_1),
        .busy(busy_1), .done(done_1), .mem(if_1.master)
    );

    always @(posedge clk or posedge reset)
        if (reset) cnt_1 <= '0;
        else if (en_1) cnt_1 <= (cnt_1 == 1'd1) ? 1'd0 : cnt_1 + 1'b1;

    always @(posedge clk) begin
        if_1.feature_data <= 5'd7;
        if_1.weight_data  <= 5'd3;
    end

    always @(negedge clk) begin
        if (if_1.fm_wb_write_en) begin
            q_1.push_back({8'(if_1.fm_wb_row), 8'(if_1.fm_wb_col), if_1.fm_wb_data});
            if (first_wr_1 < 0) first_wr_1 = cyc;
        end
        if (en_1 !== if_1.fm_wb_write_en) en_bad++;
        if (done_1) done_at_1 = cyc;
    end

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic load_ramp();
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 96; k++) fm_d[r][k] = 5'(r + 1);
        for (int k = 0; k < 96; k++)
            for (int c = 0; c < 3; c++) wm_d[k][c] = 5'(c + 1);
    endtask

    task automatic check_ramp(input string tag, input int t0);
        chk({tag, "_done_cyc"}, 32'(done_at_d - t0 + 1), 1783);
        chk({tag, "_nwr"}, q_d.size(), 18);
        for (int i = 0; i < 18; i++)
            chk({tag, "_wr"}, at(q_d, i),
                pk(i % 6, i / 6, 96 * (i % 6 + 1) * (i / 6 + 1)));
        chk({tag, "_cnt"}, 32'(cnt_d), 0);
    endtask

    int t0;

    initial begin
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) fm_s[r][k] = 5'd1;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 2; c++) wm_s[k][c] = 5'd2;
        load_ramp();

        repeat (3) @(negedge clk);
        chk("rst_ctl", {28'd0, busy_d, done_d, en_d, if_d.fm_wb_write_en}, 0);
        chk("rst_data", 32'(if_d.fm_wb_data), 0);
        chk("rst_addr", {16'd0, if_d.feature_col, if_d.weight_row, if_d.weight_col}, 0);
        reset = 1'b0;

        // Small configuration, features 1, weights 2
        @(negedge clk); start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0; t0 = cyc;
        for (int i = 0; i < 100 && done_at_s < 0; i++) @(negedge clk);
        chk("s_done_cyc", 32'(done_at_s - t0 + 1), 25);
        chk("s_nwr", q_s.size(), 4);
        for (int i = 0; i < 4; i++) chk("s_wr", at(q_s, i), pk(i % 2, i / 2, 6));
        chk("s_cnt", 32'(cnt_s), 0);

        // Default ramp, with a stray start pulse during MAC
        @(negedge clk); start_d = 1'b1;
        @(posedge clk); #1 start_d = 1'b0; t0 = cyc;
        repeat (30) @(negedge clk);
        start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        for (int i = 0; i < 2500 && done_at_d < 0; i++) @(negedge clk);
        check_ramp("ramp", t0);
        @(negedge clk);
        chk("d_idle_busy", 32'(busy_d), 0);

        // Default, all elements 31: wraps to 26720
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 96; k++) fm_d[r][k] = 5'd31;
        for (int k = 0; k < 96; k++)
            for (int c = 0; c < 3; c++) wm_d[k][c] = 5'd31;
        q_d.delete(); done_at_d = -1;
        @(negedge clk); start_d = 1'b1;
        @(posedge clk); #1 start_d = 1'b0; t0 = cyc;
        for (int i = 0; i < 2500 && done_at_d < 0; i++) @(negedge clk);
        chk("max_done_cyc", 32'(done_at_d - t0 + 1), 1783);
        chk("max_nwr", q_d.size(), 18);
        for (int i = 0; i < 18; i++) chk("max_wr", at(q_d, i), pk(i % 6, i / 6, 26720));

        // Reset in the middle of the third element, then rerun
        load_ramp();
        q_d.delete(); done_at_d = -1;
        @(negedge clk); start_d = 1'b1;
        @(posedge clk); #1 start_d = 1'b0;
        repeat (240) @(negedge clk);
        chk("mid_wr_before", q_d.size(), 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_ctl", {28'd0, busy_d, done_d, en_d, if_d.fm_wb_write_en}, 0);
        chk("mid_rst_data", 32'(if_d.fm_wb_data), 0);
        chk("mid_rst_addr", {16'd0, if_d.feature_col, if_d.weight_row, if_d.weight_col}, 0);
        chk("mid_rst_wr", {24'd0, if_d.fm_wb_row, if_d.fm_wb_col, 3'd0}, 0);
        chk("mid_rst_cnt", 32'(cnt_d), 0);
        @(negedge clk); reset = 1'b0;
        q_d.delete(); done_at_d = -1;
        @(negedge clk); start_d = 1'b1;
        @(posedge clk); #1 start_d = 1'b0; t0 = cyc;
        for (int i = 0; i < 2500 && done_at_d < 0; i++) @(negedge clk);
        check_ramp("rerun", t0);

        // Single column dot product
        @(negedge clk); start_1 = 1'b1;
        @(posedge clk); #1 start_1 = 1'b0; t0 = cyc;
        for (int i = 0; i < 50 && done_at_1 < 0; i++) @(negedge clk);
        chk("one_wr_lat", 32'(first_wr_1 - t0), 3);
        chk("one_nwr", q_1.size(), 2);
        chk("one_wr0", at(q_1, 0), pk(0, 0, 21));
        chk("one_wr1", at(q_1, 1), pk(1, 0, 21));
        chk("one_done_cyc", 32'(done_at_1 - t0 + 1), 9);

        chk("en_align", en_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
